// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - terminal-count event port (valid/ready) of the down-counter timer
interface down_counter_timer_if;
  logic tc_valid;
  logic tc_ready;

  modport master (output tc_valid, input tc_ready);
  modport slave  (input tc_valid, output tc_ready);
endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable one-shot/periodic down-counter with TC event and overrun count
// Optional tick prescaler enabled by defining DOWNCNT_PRESCALE_EN.
module down_counter_timer #(
  parameter int WIDTH      = 8,
  parameter int OVR_W      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
`ifdef DOWNCNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic [OVR_W-1:0]      overrun,
  down_counter_timer_if.master  ev
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             tick;
  logic             tc_fire;
  logic             tc_take;

`ifdef DOWNCNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == prescale);

  // Held at zero outside RUN so every entry into RUN starts a full tick period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (load || stop || state != RUN || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign tc_fire = (state == RUN) && !load && !stop && tick && (count == WIDTH'(1));
  assign tc_take = ev.tc_valid && ev.tc_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      reload      <= '0;
      busy        <= 1'b0;
      overrun     <= '0;
      ev.tc_valid <= 1'b0;
    end else begin
      if (load) begin
        count  <= load_val;
        reload <= load_val;
        state  <= IDLE;
        busy   <= 1'b0;
      end else if (stop) begin
        if (state == RUN) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start && count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          DONE: begin
            if (start && reload != '0) begin
              count <= reload;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              if (count > WIDTH'(1)) begin
                count <= count - 1'b1;
              end else if (periodic) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= DONE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end

      // A new TC while the previous one is still unaccepted is counted as lost.
      if (tc_fire) begin
        ev.tc_valid <= 1'b1;
        if (ev.tc_valid && !ev.tc_ready && overrun != {OVR_W{1'b1}}) begin
          overrun <= overrun + 1'b1;
        end
      end else if (tc_take) begin
        ev.tc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - randomized and directed checks of down_counter_timer against a reference model
module tb_down_counter_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic [3:0] overrun;
`ifdef DOWNCNT_PRESCALE_EN
  logic [3:0] prescale = 4'd0;
`endif

  down_counter_timer_if ev_if ();

  down_counter_timer dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
`ifdef DOWNCNT_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .busy     (busy),
    .overrun  (overrun),
    .ev       (ev_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: running/expired flags, a plain integer count, pending event, lost-event tally.
  int m_count, m_reload, m_lost;
  bit m_run, m_expired, m_pending;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_lost = 0;
    m_run = 0; m_expired = 0; m_pending = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit st, input bit sp,
                            input bit per, input bit rdy);
    bit was_run;
    bit tc;
    was_run = m_run;
    tc = 0;
    if (ld) begin
      m_count = lv; m_reload = lv; m_run = 0; m_expired = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (!was_run) begin
      if (st && !m_expired && m_count != 0) begin
        m_run = 1;
      end else if (st && m_expired && m_reload != 0) begin
        m_count = m_reload; m_run = 1; m_expired = 0;
      end
    end else if (m_count > 1) begin
      m_count = m_count - 1;
    end else begin
      tc = 1;
      if (per) m_count = m_reload;
      else begin
        m_count = 0; m_run = 0; m_expired = 1;
      end
    end
    if (tc) begin
      if (m_pending && !rdy && m_lost < 15) m_lost = m_lost + 1;
      m_pending = 1;
    end else if (m_pending && rdy) begin
      m_pending = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".busy"}, 32'(busy), 32'(m_run));
    check({tag, ".tc_valid"}, 32'(ev_if.tc_valid), 32'(m_pending));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_lost));
  endtask

  task automatic step(input string tag, input bit ld, input int lv, input bit st, input bit sp,
                      input bit per, input bit rdy);
    @(negedge clk);
    load = ld; load_val = 8'(lv); start = st; stop = sp; periodic = per; ev_if.tc_ready = rdy;
    @(posedge clk);
    model_step(ld, lv, st, sp, per, rdy);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    load = 0; start = 0; stop = 0; periodic = 0; ev_if.tc_ready = 0; load_val = 0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ev_if.tc_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all("por");
    @(negedge clk);
    reset = 1'b0;

    // One-shot 3,2,1,0 with TC pending
    step("os_load", 1, 3, 0, 0, 0, 0);
    step("os_start", 0, 0, 1, 0, 0, 0);
    check("os_start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) step("os_run", 0, 0, 0, 0, 0, 0);
    check("os_tc_count", 32'(count), 32'd0);
    check("os_tc_valid", 32'(ev_if.tc_valid), 32'd1);
    check("os_done_busy", 32'(busy), 32'd0);

    // Periodic 4 with consumer always ready
    do_reset();
    step("per_load", 1, 4, 0, 0, 1, 1);
    step("per_start", 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 12; i++) step("per_run", 0, 0, 0, 0, 1, 1);

    // Overrun saturation, then a consume on a non-TC edge
    do_reset();
    step("ovr_load", 1, 2, 0, 0, 1, 0);
    step("ovr_start", 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 40; i++) step("ovr_run", 0, 0, 0, 0, 1, 0);
    check("ovr_sat", 32'(overrun), 32'd15);
    check("ovr_valid", 32'(ev_if.tc_valid), 32'd1);
    step("ovr_take", 0, 0, 0, 1, 1, 1);
    check("ovr_dropped", 32'(ev_if.tc_valid), 32'd0);
    step("ovr_keep_on_load", 1, 5, 0, 0, 0, 0);
    check("ovr_kept", 32'(overrun), 32'd15);

    // Command priority: load wins over stop and start
    do_reset();
    step("pri_load", 1, 7, 0, 0, 0, 0);
    step("pri_start", 0, 0, 1, 0, 0, 0);
    step("pri_run", 0, 0, 0, 0, 0, 0);
    step("pri_run", 0, 0, 0, 0, 0, 0);
    check("pri_count5", 32'(count), 32'd5);
    step("pri_all", 1, 9, 1, 1, 0, 0);
    check("pri_count9", 32'(count), 32'd9);
    check("pri_busy", 32'(busy), 32'd0);

    // Zero load cannot start; stop/resume keeps count
    step("zero_load", 1, 0, 0, 0, 0, 0);
    step("zero_start", 0, 0, 1, 0, 0, 0);
    check("zero_busy", 32'(busy), 32'd0);
    step("sr_load", 1, 8, 0, 0, 0, 0);
    step("sr_start", 0, 0, 1, 0, 0, 0);
    step("sr_run", 0, 0, 0, 0, 0, 0);
    step("sr_run", 0, 0, 0, 0, 0, 0);
    step("sr_stop", 0, 0, 0, 1, 0, 0);
    step("sr_hold", 0, 0, 0, 0, 0, 0);
    check("sr_held6", 32'(count), 32'd6);
    step("sr_resume", 0, 0, 1, 0, 0, 0);
    step("sr_tick", 0, 0, 0, 0, 0, 0);
    check("sr_count5", 32'(count), 32'd5);

    // Asynchronous reset while running
    step("ar_run", 0, 0, 0, 0, 0, 0);
    do_reset();
    check("ar_count", 32'(count), 32'd0);

    // Randomized command mix
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 6)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
